iq_sample_packer: RTL and testbench

//  Parametrised quantise-and-pack stage for the QPSK RFNoC datapath.
//  - Input: AXI-Stream of 16-bit I/16-bit Q samples.
//  - Each component is reduced to BITS bits, by truncation or by round-half-up with saturation.
//  - K = OUT_WIDTH/(2*BITS) samples are packed into one output word.
//  - Sits between the modulator/filter output and the host-bound stream; handles packet flush and backpressure.

---
 rtl/iq_pack_pkg.sv | 26 ++
 rtl/iq_quantize.sv | 34 +++
 rtl/iq_sample_packer.sv | 122 ++++++++++++
 tb/tb_iq_sample_packer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_pack_pkg.sv
// Shared types and sizing helpers for the IQ quantise-and-pack datapath.
package iq_pack_pkg;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } iq_pair_t;

  function automatic int slots(input int out_width, input int bits);
    return out_width / (2 * bits);
  endfunction

  function automatic int cnt_w(input int k);
    return (k < 1) ? 1 : $clog2(k + 1);
  endfunction

  // Half of the kept LSB, expressed in the 17-bit widened input domain.
  function automatic logic [16:0] half_lsb(input int bits);
    return 17'(1) << (15 - bits);
  endfunction

  function automatic logic [15:0] max_pos(input int bits);
    return (16'(1) << (bits - 1)) - 16'(1);
  endfunction

endpackage

// File: rtl/iq_quantize.sv
// Reduces one signed 16-bit component to BITS bits by truncation or
// round-half-up with positive saturation.
module iq_quantize
  import iq_pack_pkg::*;
#(
  parameter int BITS  = 4,
  parameter int ROUND = 0
) (
  input  logic [15:0]     x_i,
  output logic [BITS-1:0] q_o,
  output logic            sat_o
);

  if (ROUND == 0 || BITS == 16) begin : g_trunc
    assign q_o   = x_i[15 -: BITS];
    assign sat_o = 1'b0;
    if (BITS < 16) begin : g_lsb
      logic unused_lsbs;
      assign unused_lsbs = ^x_i[15-BITS:0];
    end
  end else begin : g_round
    localparam logic [16:0] HALF = half_lsb(BITS);
    localparam logic [15:0] MAXP = max_pos(BITS);
    logic [16:0] y;
    logic        unused_bits;

    assign y = {x_i[15], x_i} + HALF;
    // A non-negative input that carries into bit 15 has overflowed the signed range.
    assign sat_o       = ~x_i[15] & (y[16:15] == 2'b01);
    assign q_o         = sat_o ? MAXP[BITS-1:0] : y[15 -: BITS];
    assign unused_bits = ^y[15-BITS:0];
  end

endmodule

// File: rtl/iq_sample_packer.sv
// Quantises {I,Q} samples and packs K of them per output word, with packet
// flush on tlast, a registered output stage and a saturation event counter.
module iq_sample_packer
  import iq_pack_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32,
  parameter int BITS      = 4,
  parameter int ROUND     = 0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [IN_WIDTH-1:0]                       i_tdata,
  input  logic                                      i_tlast,
  input  logic                                      i_tvalid,
  output logic                                      i_tready,
  output logic [OUT_WIDTH-1:0]                      o_tdata,
  output logic                                      o_tlast,
  output logic [cnt_w(slots(OUT_WIDTH, BITS))-1:0]  o_tcount,
  output logic                                      o_tvalid,
  input  logic                                      o_tready,
  output logic [15:0]                               sat_count
);

  localparam int K  = slots(OUT_WIDTH, BITS);
  localparam int CW = cnt_w(K);
  localparam int SW = 2 * BITS;

  iq_pair_t        sample;
  logic [BITS-1:0] quant_i, quant_q;
  logic            sat_flag_i, sat_flag_q;
  logic            accept, word_done;
  logic [OUT_WIDTH-1:0] slot_word;

  logic [CW-1:0]        slot_q, slot_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] tdata_q, tdata_d;
  logic                 tlast_q, tlast_d;
  logic [CW-1:0]        tcount_q, tcount_d;
  logic                 tvalid_q, tvalid_d;
  logic [15:0]          sat_cnt_q, sat_cnt_d;

  assign sample = i_tdata;

  iq_quantize #(.BITS(BITS), .ROUND(ROUND)) u_quant_i (
    .x_i   (sample.i),
    .q_o   (quant_i),
    .sat_o (sat_flag_i)
  );

  iq_quantize #(.BITS(BITS), .ROUND(ROUND)) u_quant_q (
    .x_i   (sample.q),
    .q_o   (quant_q),
    .sat_o (sat_flag_q)
  );

  assign i_tready  = ~tvalid_q | o_tready;
  assign accept    = i_tvalid & i_tready;
  assign word_done = i_tlast | (slot_q == CW'(K - 1));

  // Slot 0 sits in the MSBs; later slots shift down by one slot width each.
  assign slot_word = (OUT_WIDTH'({quant_i, quant_q}) << (OUT_WIDTH - SW))
                     >> (SW * int'(slot_q));

  always_comb begin
    slot_d    = slot_q;
    acc_d     = acc_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    tcount_d  = tcount_q;
    tvalid_d  = tvalid_q;
    sat_cnt_d = sat_cnt_q;

    if (accept) begin
      sat_cnt_d = sat_cnt_q + 16'(sat_flag_i) + 16'(sat_flag_q);
    end

    if (accept && word_done) begin
      tdata_d  = acc_q | slot_word;
      tlast_d  = i_tlast;
      tcount_d = slot_q + CW'(1);
      tvalid_d = 1'b1;
      acc_d    = '0;
      slot_d   = '0;
    end else begin
      if (accept) begin
        acc_d  = acc_q | slot_word;
        slot_d = slot_q + CW'(1);
      end
      if (tvalid_q && o_tready) begin
        tvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q    <= '0;
      acc_q     <= '0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      tcount_q  <= '0;
      tvalid_q  <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      slot_q    <= slot_d;
      acc_q     <= acc_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      tcount_q  <= tcount_d;
      tvalid_q  <= tvalid_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign o_tdata   = tdata_q;
  assign o_tlast   = tlast_q;
  assign o_tcount  = tcount_q;
  assign o_tvalid  = tvalid_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_iq_sample_packer.sv
// Bench for iq_sample_packer: a truncating and a rounding instance share one
// stimulus stream and are checked every cycle against an arithmetic model.
module tb_iq_sample_packer;

  localparam int K = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_tdata;
  logic        i_tlast, i_tvalid, o_tready;
  logic        i_tready0, i_tready1, o_tvalid0, o_tvalid1, o_tlast0, o_tlast1;
  logic [31:0] o_tdata0, o_tdata1;
  logic [2:0]  o_tcount0, o_tcount1;
  logic [15:0] sat0, sat1;

  iq_sample_packer #(.IN_WIDTH(32), .OUT_WIDTH(32), .BITS(4), .ROUND(0)) dut0 (
    .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready0), .o_tdata(o_tdata0),
    .o_tlast(o_tlast0), .o_tcount(o_tcount0), .o_tvalid(o_tvalid0),
    .o_tready(o_tready), .sat_count(sat0)
  );

  iq_sample_packer #(.IN_WIDTH(32), .OUT_WIDTH(32), .BITS(4), .ROUND(1)) dut1 (
    .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready1), .o_tdata(o_tdata1),
    .o_tlast(o_tlast1), .o_tcount(o_tcount1), .o_tvalid(o_tvalid1),
    .o_tready(o_tready), .sat_count(sat1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [2:0]  cnt;
    logic [31:0] d0;
    logic [31:0] d1;
  } word_t;

  word_t       exp_q[$];
  word_t       log_q[$];
  logic [31:0] part0, part1;
  int          nfill, sat_m0, sat_m1;
  int          errors = 0;
  int          checks = 0;
  int          rdy_mode = 1;
  bit          rdy_m, s_a, s_b, s_c, s_d;
  logic [3:0]  a0, b0, a1, b1;
  logic [31:0] held;
  logic [15:0] sat_before;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Quantisation as arithmetic: floor division by the LSB weight, with
  // half an LSB added first when rounding, clamped to +7.
  function automatic logic [3:0] q_model(input logic [15:0] x, input bit rnd, output bit sat);
    int xs, v;
    xs  = int'($signed(x));
    sat = 1'b0;
    if (!rnd) v = xs >>> 12;
    else begin
      v = (xs + 2048) >>> 12;
      if (v > 7) begin
        v   = 7;
        sat = 1'b1;
      end
    end
    return v[3:0];
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_tvalid", 64'({o_tvalid0, o_tvalid1}), 64'd0);
      chk("rst_tdata", 64'({o_tdata0, o_tdata1}), 64'd0);
      chk("rst_tcount_tlast", 64'({o_tcount0, o_tcount1, o_tlast0, o_tlast1}), 64'd0);
      chk("rst_sat_count", 64'({sat0, sat1}), 64'd0);
      exp_q.delete();
      log_q.delete();
      part0 = '0; part1 = '0; nfill = 0; sat_m0 = 0; sat_m1 = 0;
    end else begin
      rdy_m = (exp_q.size() == 0) || o_tready;
      chk("tvalid", 64'({o_tvalid0, o_tvalid1}), 64'({2{exp_q.size() != 0}}));
      chk("i_tready", 64'({i_tready0, i_tready1}), 64'({2{rdy_m}}));
      chk("sat_count", 64'({sat0, sat1}), 64'({sat_m0[15:0], sat_m1[15:0]}));
      if (exp_q.size() != 0) begin
        chk("word_trunc", 64'({o_tlast0, o_tcount0, o_tdata0}),
            64'({exp_q[0].last, exp_q[0].cnt, exp_q[0].d0}));
        chk("word_round", 64'({o_tlast1, o_tcount1, o_tdata1}),
            64'({exp_q[0].last, exp_q[0].cnt, exp_q[0].d1}));
        if (o_tready) begin
          log_q.push_back(word_t'({o_tlast0, o_tcount0, o_tdata0, o_tdata1}));
          void'(exp_q.pop_front());
        end
      end
      if (i_tvalid && rdy_m) begin
        a0 = q_model(i_tdata[31:16], 1'b0, s_a);
        b0 = q_model(i_tdata[15:0], 1'b0, s_b);
        a1 = q_model(i_tdata[31:16], 1'b1, s_c);
        b1 = q_model(i_tdata[15:0], 1'b1, s_d);
        part0 = part0 | (32'({a0, b0}) << (24 - 8 * nfill));
        part1 = part1 | (32'({a1, b1}) << (24 - 8 * nfill));
        nfill++;
        sat_m0 = sat_m0 + int'(s_a) + int'(s_b);
        sat_m1 = sat_m1 + int'(s_c) + int'(s_d);
        if (nfill == K || i_tlast) begin
          exp_q.push_back(word_t'({i_tlast, 3'(nfill), part0, part1}));
          part0 = '0; part1 = '0; nfill = 0;
        end
      end
    end
  end

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       o_tready = 1'b0;
        2:       o_tready = ($urandom_range(0, 3) != 0);
        default: o_tready = 1'b1;
      endcase
    end
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic send(input logic [15:0] si, input logic [15:0] sq, input logic sl);
    int n = 0;
    i_tdata = {si, sq}; i_tlast = sl; i_tvalid = 1'b1;
    @(negedge clk);
    while (!i_tready0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 64'(n < 200), 64'd1);
    @(posedge clk); #1;
    i_tvalid = 1'b0; i_tlast = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (o_tvalid0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n < 100), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic expect_log(input string nm, input int idx, input logic [35:0] w0,
                            input logic [31:0] d1);
    if (idx < log_q.size()) begin
      chk({nm, "_trunc"}, 64'({log_q[idx].last, log_q[idx].cnt, log_q[idx].d0}), 64'(w0));
      chk({nm, "_round"}, 64'(log_q[idx].d1), 64'(d1));
    end else begin
      chk({nm, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Truncation packing
    send(16'h1000, 16'h2000, 1'b0); send(16'h3000, 16'h4000, 1'b0);
    send(16'h5000, 16'h6000, 1'b0); send(16'h7000, 16'h8000, 1'b0);
    drain();
    chk("t1_nwords", 64'(log_q.size()), 64'd1);
    expect_log("t1_word", 0, {1'b0, 3'd4, 32'h12345678}, 32'h12345678);

    // Early tlast, then a single-sample packet starting at slot 0
    log_q.delete();
    send(16'h1000, 16'h2000, 1'b0); send(16'h3000, 16'h4000, 1'b1);
    send(16'h5000, 16'h6000, 1'b1);
    drain();
    chk("t2_nwords", 64'(log_q.size()), 64'd2);
    expect_log("t2_early", 0, {1'b1, 3'd2, 32'h12340000}, 32'h12340000);
    expect_log("t2_single", 1, {1'b1, 3'd1, 32'h56000000}, 32'h56000000);

    // Backpressure with a pending word and a waiting sample
    log_q.delete();
    rdy_mode = 0;
    fork
      begin
        send(16'h1000, 16'h2000, 1'b0); send(16'h3000, 16'h4000, 1'b0);
        send(16'h5000, 16'h6000, 1'b0); send(16'h7000, 16'h8000, 1'b0);
        send(16'h9000, 16'hA000, 1'b0); send(16'hB000, 16'hC000, 1'b0);
        send(16'hD000, 16'hE000, 1'b0); send(16'hF000, 16'h0000, 1'b0);
      end
      begin : stall
        int n = 0;
        @(negedge clk);
        while (!o_tvalid0 && n < 50) begin
          @(negedge clk);
          n++;
        end
        held = o_tdata0;
        repeat (5) begin
          @(negedge clk);
          chk("t3_stall_ready", 64'(i_tready0), 64'd0);
          chk("t3_stall_data", 64'(o_tdata0), 64'(held));
        end
        chk("t3_held_word", 64'(held), 64'h12345678);
        @(posedge clk); #1 rdy_mode = 1;
      end
    join
    drain();
    chk("t3_nwords", 64'(log_q.size()), 64'd2);
    expect_log("t3_word0", 0, {1'b0, 3'd4, 32'h12345678}, 32'h12345678);
    expect_log("t3_word1", 1, {1'b0, 3'd4, 32'h9ABCDEF0}, 32'h9ABCDEF0);

    // Rounding and saturation
    log_q.delete();
    sat_before = sat1;
    send(16'h0800, 16'h0000, 1'b0); send(16'h07FF, 16'h0000, 1'b0);
    send(16'hF800, 16'h0000, 1'b0); send(16'h7900, 16'h0000, 1'b0);
    drain();
    expect_log("t4_word", 0, {1'b0, 3'd4, 32'h0000F070}, 32'h10000070);
    chk("t4_sat_round", 64'(sat1), 64'(sat_before + 16'd1));
    chk("t4_sat_trunc", 64'(sat0), 64'd0);

    // Reset mid-word discards the partial accumulator
    send(16'h1111, 16'h2222, 1'b0); send(16'h3333, 16'h4444, 1'b0);
    do_reset();
    send(16'h5000, 16'h6000, 1'b0); send(16'h7000, 16'h8000, 1'b0);
    send(16'h9000, 16'hA000, 1'b0); send(16'hB000, 16'hC000, 1'b0);
    drain();
    chk("t5_nwords", 64'(log_q.size()), 64'd1);
    expect_log("t5_word", 0, {1'b0, 3'd4, 32'h56789ABC}, 32'h56789ABC);

    // Saturation burst up to 0xFFFF and wrap, then random traffic
    do_reset();
    for (int i = 0; i < 32767; i++) send(16'h7FFF, 16'h7FFF, 1'b0);
    send(16'h7FFF, 16'h0000, 1'b1);
    drain();
    chk("t6_sat_ffff", 64'(sat1), 64'hFFFF);
    send(16'h7FFF, 16'h0000, 1'b1);
    drain();
    chk("t6_sat_wrap", 64'(sat1), 64'd0);
    rdy_mode = 2;
    for (int i = 0; i < 4096; i++)
      send(16'($urandom), 16'($urandom), (i == 4095) || ($urandom_range(0, 15) == 0));
    rdy_mode = 1;
    drain();
    chk("t6_model_empty", 64'(exp_q.size()), 64'd0);
    chk("t6_partial_empty", 64'(nfill), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
